pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 32-bit RV32I core. Watches the register reads of the instruction in decode, the instruction held in `id_ex`/ex, and the ex-stage jump and multi-cycle-op signals. From these it drives the hold and flush controls for `pc_reg`, `if_id` and `id_ex`. It sequences three events:

- load-use stalls, which insert bubbles;
- ex-stage jumps, which flush the two younger stages and redirect the PC;
- multi-cycle ex operations, which freeze the front of the pipe until done.

## Interface
Parameters:
- `LU_BUBBLES`, default 1: bubbles inserted per load-use hazard (1..7).
- `MC_TIMEOUT`, default 64: maximum wait-for-done cycles before abort (2..255).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1_addr_i`  in  5  rs1 index read by the decode instruction.
- `id_rs2_addr_i`  in  5  rs2 index read by the decode instruction.
- `id_rs1_ren_i`  in  1  decode instruction really reads rs1.
- `id_rs2_ren_i`  in  1  decode instruction really reads rs2.
- `ex_rd_addr_i`  in  5  rd of the instruction in ex.
- `ex_reg_wen_i`  in  1  ex instruction writes rd.
- `ex_is_load_i`  in  1  ex instruction is a load.
- `ex_jump_en_i`  in  1  ex resolves a taken jump/branch this cycle.
- `ex_jump_addr_i`  in  32  jump target.
- `ex_mc_start_i`  in  1  ex instruction is a multi-cycle op.
- `mc_done_i`  in  1  multi-cycle unit result valid this cycle.
- `hold_pc_o`  out  1  `pc_reg` keeps its value.
- `hold_if_id_o`  out  1  `if_id` keeps its contents.
- `hold_id_ex_o`  out  1  `id_ex` keeps its contents.
- `flush_if_id_o`  out  1  `if_id` loads NOP (0x00000013).
- `flush_id_ex_o`  out  1  `id_ex` loads bubble (NOP, `reg_wen`=0).
- `jump_en_o`  out  1  `pc_reg` loads `jump_addr_o`.
- `jump_addr_o`  out  32  PC redirect target.
- `mc_timeout_o`  out  1  sticky: a multi-cycle op exceeded `MC_TIMEOUT`.
- `stall_cnt_o`  out  32  count of cycles with `hold_pc_o`=1.

## Operation
- State register has three states: RUN, STALL_LU, WAIT_MC. There is also a 3-bit bubble counter `bcnt` and an 8-bit wait counter `wcnt`.
- All control outputs are combinational from the current state and inputs. State, counters, `mc_timeout_o` and `stall_cnt_o` are registered.
- Hazard term `lu`: true when all of the following hold:
  - `ex_is_load_i` & `ex_reg_wen_i`;
  - `ex_rd_addr_i`≠0;
  - (`id_rs1_ren_i` & rs1==rd) | (`id_rs2_ren_i` & rs2==rd).
- RUN, priority jump > mc > lu:
  - **Jump:** `jump_en_o`=1, `jump_addr_o`=`ex_jump_addr_i`, `flush_if_id_o`=1, `flush_id_ex_o`=1, no holds; stay in RUN.
  - **mc_start & mc_done same cycle:** no action; stay in RUN.
  - **mc_start only:** `hold_pc_o`, `hold_if_id_o` and `hold_id_ex_o` all 1; `wcnt`←1; go to WAIT_MC.
  - **lu:** `hold_pc_o`=1, `hold_if_id_o`=1, `flush_id_ex_o`=1.
    - If `LU_BUBBLES`==1, stay in RUN.
    - Otherwise `bcnt`←`LU_BUBBLES`−1 and go to STALL_LU.
  - **None of the above:** all outputs 0.
- STALL_LU:
  - Drive the lu output set each cycle and decrement `bcnt`. Go to RUN in the cycle `bcnt`==1.
  - `ex_jump_en_i` overrides: drive the jump output set and go to RUN immediately.
- WAIT_MC:
  - `ex_jump_en_i` is ignored.
  - **`mc_done_i`=1:** all holds 0 this cycle; go to RUN.
  - **No done, `wcnt`==`MC_TIMEOUT`:** holds 0 and `flush_id_ex_o`=1 (drop the op); `mc_timeout_o`←1; go to RUN.
  - **Otherwise:** all three holds 1 and `wcnt`++.
- Flush and hold on the same register are never both asserted.
- `stall_cnt_o` increments when `hold_pc_o`=1 and saturates at 0xFFFFFFFF.
- `mc_timeout_o` is cleared only by `rst`.

## Timing
- Reset behaviour:
  - While `rst`=1, all outputs are forced to 0 regardless of inputs.
  - On the first edge with `rst`=1: state←RUN, `bcnt`=0, `wcnt`=0, `stall_cnt_o`=0, `mc_timeout_o`=0.
  - Reset in STALL_LU or WAIT_MC aborts the stall at once.
- Control outputs have 0-cycle latency; `pc_reg`, `if_id` and `id_ex` sample them on the same edge.
- A load-use hazard costs exactly `LU_BUBBLES` cycles of `hold_pc_o`.
- A multi-cycle op whose done arrives N cycles after start (N≥1) costs N held cycles. The cycle with done is not held.
- Timeout: an op started at cycle t with no done is dropped at cycle t+`MC_TIMEOUT`. `mc_timeout_o` is visible from t+`MC_TIMEOUT`+1.
- `jump_addr_o` is a pass-through of `ex_jump_addr_i` when `jump_en_o`=1, and 0 otherwise.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all inputs toggling -> all outputs 0 throughout; `stall_cnt_o`=0 after release.
- **Load-use, `LU_BUBBLES`=2:** ex = load rd=x5, decode = add reading rs2=x5 -> `hold_pc_o`/`hold_if_id_o`/`flush_id_ex_o`=1 for exactly 2 cycles; `stall_cnt_o`=2.
- **rd=x0 or ren=0:** load rd=x0 with rs1=x0 read, then load rd=x5 with `id_rs1_ren_i`=0 and rs1=x5 -> no hold or flush.
- **Jump vs hazard:** `ex_jump_en_i`=1, target 0x00000080, with lu true the same cycle -> `jump_en_o`=1, `jump_addr_o`=0x00000080, both flushes 1, no holds.
- **Multi-cycle op:** `ex_mc_start_i` at t, `mc_done_i` at t+5 -> holds at t..t+4, released at t+5; a jump at t+2 is ignored; `stall_cnt_o`=5.
- **Timeout, `MC_TIMEOUT`=4:** start with no done -> holds for 4 cycles, `flush_id_ex_o` pulse at t+4, `mc_timeout_o`=1 from t+5 and stays 1 until `rst`.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect sequencing for the RV32I pipeline front end.
// Arbitrates ex-stage jumps, multi-cycle ex operations and load-use hazards
// and drives the pc_reg / if_id / id_ex control strobes combinationally so
// the pipeline registers act on them at the same clock edge.
module pipe_ctrl #(
    parameter int unsigned LU_BUBBLES = 1,   // bubbles per load-use hazard, 1..7
    parameter int unsigned MC_TIMEOUT = 64   // wait-for-done limit, 2..255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_ren_i,
    input  logic        id_rs2_ren_i,

    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_reg_wen_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        ex_mc_start_i,
    input  logic        mc_done_i,

    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        mc_timeout_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_LU = 2'd1,
        WAIT_MC  = 2'd2
    } state_t;

    // Remaining bubbles after the first one, which is issued from RUN.
    localparam logic [2:0] BCNT_INIT  = 3'(LU_BUBBLES - 1);
    localparam logic [7:0] WCNT_LIMIT = 8'(MC_TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        mc_timeout_q;
    logic        timeout_set;
    logic [31:0] stall_cnt_q;

    logic        lu;
    logic        hold_pc, hold_if_id, hold_id_ex;
    logic        flush_if_id, flush_id_ex;
    logic        jump_en;
    logic [31:0] jump_addr;

    // A load in ex whose (non-x0) destination is really read by decode.
    function automatic logic load_use_hit(
        input logic       is_load,
        input logic       reg_wen,
        input logic [4:0] rd,
        input logic       rs1_ren,
        input logic [4:0] rs1,
        input logic       rs2_ren,
        input logic [4:0] rs2
    );
        logic src_match;
        src_match = (rs1_ren && (rs1 == rd)) || (rs2_ren && (rs2 == rd));
        return is_load && reg_wen && (rd != 5'd0) && src_match;
    endfunction

    // Saturating increment for the stall statistics counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    assign lu = load_use_hit(ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i,
                             id_rs1_ren_i, id_rs1_addr_i,
                             id_rs2_ren_i, id_rs2_addr_i);

    // Next-state and control-strobe decode; priority jump > multi-cycle > load-use.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        wcnt_d      = wcnt_q;
        timeout_set = 1'b0;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = 32'd0;

        unique case (state_q)
            RUN: begin
                if (ex_jump_en_i) begin
                    jump_en     = 1'b1;
                    jump_addr   = ex_jump_addr_i;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (ex_mc_start_i) begin
                    // A result that is ready in the start cycle needs no freeze.
                    if (!mc_done_i) begin
                        hold_pc    = 1'b1;
                        hold_if_id = 1'b1;
                        hold_id_ex = 1'b1;
                        wcnt_d     = 8'd1;
                        state_d    = WAIT_MC;
                    end
                end else if (lu) begin
                    hold_pc     = 1'b1;
                    hold_if_id  = 1'b1;
                    flush_id_ex = 1'b1;
                    if (BCNT_INIT != 3'd0) begin
                        bcnt_d  = BCNT_INIT;
                        state_d = STALL_LU;
                    end
                end
            end

            STALL_LU: begin
                if (ex_jump_en_i) begin
                    // The jump kills the stalled decode instruction anyway.
                    jump_en     = 1'b1;
                    jump_addr   = ex_jump_addr_i;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    bcnt_d      = 3'd0;
                    state_d     = RUN;
                end else begin
                    hold_pc     = 1'b1;
                    hold_if_id  = 1'b1;
                    flush_id_ex = 1'b1;
                    bcnt_d      = bcnt_q - 3'd1;
                    if (bcnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end

            WAIT_MC: begin
                // The ex instruction is frozen, so any jump it reports is stale.
                if (mc_done_i) begin
                    wcnt_d  = 8'd0;
                    state_d = RUN;
                end else if (wcnt_q >= WCNT_LIMIT) begin
                    // Give up on the op: release the front end and bubble id_ex.
                    flush_id_ex = 1'b1;
                    timeout_set = 1'b1;
                    wcnt_d      = 8'd0;
                    state_d     = RUN;
                end else begin
                    hold_pc    = 1'b1;
                    hold_if_id = 1'b1;
                    hold_id_ex = 1'b1;
                    wcnt_d     = wcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = RUN;
                bcnt_d  = 3'd0;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // State and sequencing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            bcnt_q  <= 3'd0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Sticky timeout flag and saturating count of PC-hold cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= 32'd0;
        end else begin
            mc_timeout_q <= mc_timeout_q | timeout_set;
            if (hold_pc) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
        end
    end

    // Reset masks every output, including the registered ones, immediately.
    assign hold_pc_o     = hold_pc     & ~rst;
    assign hold_if_id_o  = hold_if_id  & ~rst;
    assign hold_id_ex_o  = hold_id_ex  & ~rst;
    assign flush_if_id_o = flush_if_id & ~rst;
    assign flush_id_ex_o = flush_id_ex & ~rst;
    assign jump_en_o     = jump_en     & ~rst;
    assign jump_addr_o   = rst ? 32'd0 : jump_addr;
    assign mc_timeout_o  = mc_timeout_q & ~rst;
    assign stall_cnt_o   = rst ? 32'd0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two pipe_ctrl instances with different parameters share one
// randomized/directed input stream; a reference model pushes expected outputs
// into per-instance queues and a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    localparam int NI = 2;
    localparam int LUB0 = 2, TO0 = 8;
    localparam int LUB1 = 1, TO1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        ren1 = 0, ren2 = 0, wen = 0, isload = 0, jump = 0, start = 0, done = 0;
    logic [31:0] jaddr = '0;

    logic        o_hpc [NI];
    logic        o_hif [NI];
    logic        o_hie [NI];
    logic        o_fif [NI];
    logic        o_fie [NI];
    logic        o_jen [NI];
    logic [31:0] o_jad [NI];
    logic        o_to  [NI];
    logic [31:0] o_cnt [NI];

    pipe_ctrl #(.LU_BUBBLES(LUB0), .MC_TIMEOUT(TO0)) u_dut0 (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_ren_i(ren1), .id_rs2_ren_i(ren2),
        .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(isload),
        .ex_jump_en_i(jump), .ex_jump_addr_i(jaddr),
        .ex_mc_start_i(start), .mc_done_i(done),
        .hold_pc_o(o_hpc[0]), .hold_if_id_o(o_hif[0]), .hold_id_ex_o(o_hie[0]),
        .flush_if_id_o(o_fif[0]), .flush_id_ex_o(o_fie[0]),
        .jump_en_o(o_jen[0]), .jump_addr_o(o_jad[0]),
        .mc_timeout_o(o_to[0]), .stall_cnt_o(o_cnt[0])
    );

    pipe_ctrl #(.LU_BUBBLES(LUB1), .MC_TIMEOUT(TO1)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_ren_i(ren1), .id_rs2_ren_i(ren2),
        .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(isload),
        .ex_jump_en_i(jump), .ex_jump_addr_i(jaddr),
        .ex_mc_start_i(start), .mc_done_i(done),
        .hold_pc_o(o_hpc[1]), .hold_if_id_o(o_hif[1]), .hold_id_ex_o(o_hie[1]),
        .flush_if_id_o(o_fif[1]), .flush_id_ex_o(o_fie[1]),
        .jump_en_o(o_jen[1]), .jump_addr_o(o_jad[1]),
        .mc_timeout_o(o_to[1]), .stall_cnt_o(o_cnt[1])
    );

    typedef struct packed {
        logic        hold_pc;
        logic        hold_if_id;
        logic        hold_id_ex;
        logic        flush_if_id;
        logic        flush_id_ex;
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        mc_timeout;
        logic [31:0] stall_cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;

    // Reference model state: bubbles still owed after this cycle, cycles an
    // in-flight multi-cycle op has been waiting (0 = none), sticky timeout, stall count.
    int          lu_owed [NI];
    int          mc_wait [NI];
    bit          to_flag [NI];
    logic [31:0] hcount  [NI];
    int          lub     [NI];
    int          tol     [NI];

    function automatic exp_t lu_set(input exp_t e);
        exp_t r = e;
        r.hold_pc = 1; r.hold_if_id = 1; r.flush_id_ex = 1;
        return r;
    endfunction

    function automatic exp_t jump_set(input exp_t e, input logic [31:0] a);
        exp_t r = e;
        r.jump_en = 1; r.jump_addr = a; r.flush_if_id = 1; r.flush_id_ex = 1;
        return r;
    endfunction

    function automatic exp_t freeze_set(input exp_t e);
        exp_t r = e;
        r.hold_pc = 1; r.hold_if_id = 1; r.hold_id_ex = 1;
        return r;
    endfunction

    task automatic model_step(input int k, output exp_t e);
        bit hazard;
        e = '0;
        if (rst) begin
            lu_owed[k] = 0; mc_wait[k] = 0; to_flag[k] = 0; hcount[k] = 32'd0;
            return;
        end
        e.mc_timeout = to_flag[k];
        e.stall_cnt  = hcount[k];
        hazard = isload && wen && (rd != 0) &&
                 ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
        if (mc_wait[k] > 0) begin
            if (done) begin
                mc_wait[k] = 0;
            end else if (mc_wait[k] == tol[k]) begin
                e.flush_id_ex = 1;
                to_flag[k] = 1;
                mc_wait[k] = 0;
            end else begin
                e = freeze_set(e);
                mc_wait[k]++;
            end
        end else if (lu_owed[k] > 0) begin
            if (jump) begin
                e = jump_set(e, jaddr);
                lu_owed[k] = 0;
            end else begin
                e = lu_set(e);
                lu_owed[k]--;
            end
        end else if (jump) begin
            e = jump_set(e, jaddr);
        end else if (start) begin
            if (!done) begin
                e = freeze_set(e);
                mc_wait[k] = 1;
            end
        end else if (hazard) begin
            e = lu_set(e);
            lu_owed[k] = lub[k] - 1;
        end
        if (e.hold_pc && hcount[k] != 32'hFFFF_FFFF) hcount[k] = hcount[k] + 1;
    endtask

    task automatic push_expected();
        exp_t e;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic compare(input int k, input exp_t e);
        chk("hold_pc",     k, 32'(o_hpc[k]), 32'(e.hold_pc));
        chk("hold_if_id",  k, 32'(o_hif[k]), 32'(e.hold_if_id));
        chk("hold_id_ex",  k, 32'(o_hie[k]), 32'(e.hold_id_ex));
        chk("flush_if_id", k, 32'(o_fif[k]), 32'(e.flush_if_id));
        chk("flush_id_ex", k, 32'(o_fie[k]), 32'(e.flush_id_ex));
        chk("jump_en",     k, 32'(o_jen[k]), 32'(e.jump_en));
        chk("jump_addr",   k, o_jad[k],      e.jump_addr);
        chk("mc_timeout",  k, 32'(o_to[k]),  32'(e.mc_timeout));
        chk("stall_cnt",   k, o_cnt[k],      e.stall_cnt);
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; ren1 = 0; ren2 = 0; wen = 0;
        isload = 0; jump = 0; jaddr = 0; start = 0; done = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(3))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd7;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_inputs(input bit allow_rst);
        rst    = allow_rst && ($urandom_range(199) == 0);
        rd     = pick_reg();
        rs1    = pick_reg();
        rs2    = pick_reg();
        ren1   = 1'($urandom);
        ren2   = 1'($urandom);
        wen    = ($urandom_range(3) != 0);
        isload = 1'($urandom);
        jump   = ($urandom_range(7) == 0);
        jaddr  = $urandom;
        start  = ($urandom_range(9) == 0);
        done   = ($urandom_range(3) == 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle(); idle_inputs(); push_expected();
        end
    endtask

    initial begin
        lub[0] = LUB0; tol[0] = TO0;
        lub[1] = LUB1; tol[1] = TO1;
        for (int k = 0; k < NI; k++) begin
            lu_owed[k] = 0; mc_wait[k] = 0; to_flag[k] = 0; hcount[k] = 0;
        end

        // Reset held with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); rand_inputs(1'b0); rst = 1; push_expected();
        end
        idle_cycles(2);

        // Load-use: load x5 in ex, decode reads x5 through rs2 for two cycles.
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle_inputs();
            isload = 1; wen = 1; rd = 5'd5; ren2 = 1; rs2 = 5'd5; rs1 = 5'd3; ren1 = 1;
            push_expected();
        end
        idle_cycles(2);

        // No hazard on x0 destination or on an unread source.
        next_cycle(); idle_inputs();
        isload = 1; wen = 1; rd = 5'd0; ren1 = 1; rs1 = 5'd0; push_expected();
        next_cycle(); idle_inputs();
        isload = 1; wen = 1; rd = 5'd5; ren1 = 0; rs1 = 5'd5; push_expected();

        // Jump wins over a simultaneous load-use hazard.
        next_cycle(); idle_inputs();
        isload = 1; wen = 1; rd = 5'd5; ren1 = 1; rs1 = 5'd5;
        jump = 1; jaddr = 32'h0000_0080; push_expected();
        idle_cycles(1);

        // Multi-cycle op: start at t, stale jump at t+2, done at t+5.
        next_cycle(); idle_inputs(); start = 1; push_expected();
        for (int i = 1; i <= 5; i++) begin
            next_cycle(); idle_inputs();
            if (i == 2) begin jump = 1; jaddr = 32'h0000_1234; end
            if (i == 5) done = 1;
            push_expected();
        end
        idle_cycles(2);

        // Start and done in the same cycle: nothing happens.
        next_cycle(); idle_inputs(); start = 1; done = 1; push_expected();
        idle_cycles(1);

        // Timeout: start with no done ever.
        next_cycle(); idle_inputs(); start = 1; push_expected();
        idle_cycles(12);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            next_cycle(); rand_inputs(1'b1); push_expected();
        end

        // Reset clears the sticky flag and the counter.
        next_cycle(); idle_inputs(); rst = 1; push_expected();
        idle_cycles(3);

        next_cycle();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
